i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
- Output stage directly downstream of midi_synth.
- Consumes the 16-bit mixed sample (output_sample) through a one-deep valid/ready buffer.
- Serialises it as mono (same sample in L and R slots) onto a standard I2S bus (BCLK, LRCK, SDATA) for an external audio DAC.
- All timing is derived from i_clk by a counter divider.
- Emits a per-frame tick so the voice path can pace sample production.

Parameters:
- CLK_DIV, 4: i_clk cycles per BCLK half-period. Legal range ≥ 2. BCLK = f(i_clk) / (2·CLK_DIV).
- WIDTH, 16: sample width in bits. Samples are two's complement.
- SLOT_BITS, 32: BCLK cycles per channel slot. Must satisfy SLOT_BITS > WIDTH. Frame length = 2·SLOT_BITS BCLK cycles.

Ports:
- i_clk, input, 1: system clock.
- i_reset, input, 1: synchronous, active-high reset.
- i_sample, input, WIDTH: signed sample to play (midi_synth output_sample).
- i_sample_valid, input, 1: i_sample is presented this cycle.
- o_sample_ready, output, 1: buffer can accept a sample this cycle.
- o_frame_tick, output, 1: one-cycle pulse when a new frame is loaded.
- o_underrun, output, 1: sticky flag; a frame started with the buffer empty.
- o_bclk, output, 1: I2S bit clock.
- o_lrck, output, 1: I2S word select. 0 = left, 1 = right.
- o_sdata, output, 1: I2S serial data, MSB first.

Behaviour:
- Reset, applied on the i_clk edge while i_reset = 1, sets:
  - o_bclk = 0, o_lrck = 0, o_sdata = 0, o_frame_tick = 0, o_underrun = 0, o_sample_ready = 1.
  - Divider counter = 0, bit counter = 0, buffer empty, frame register = 0.
- Reset asserted mid-frame aborts the frame immediately. No partial data is emitted after reset deasserts.
- Divider:
  - div_cnt counts 0..CLK_DIV-1. On reaching CLK_DIV-1 it wraps to 0 and o_bclk toggles.
  - A 1→0 toggle is a "fall event".
- Bit counter:
  - bit_cnt counts 0..2·SLOT_BITS-1 and advances on each fall event, wrapping to 0.
  - slot index b = bit_cnt mod SLOT_BITS.
  - o_lrck = 0 while bit_cnt < SLOT_BITS, else 1. It is registered on the same fall event.
- Data timing:
  - o_sdata, o_lrck and bit_cnt update only on fall events, so the DAC samples them on BCLK rising edges.
  - I2S one-bit delay: at b = 0, o_sdata = 0.
  - At b = 1..WIDTH, o_sdata = frame_reg[WIDTH-b] (MSB at b = 1).
  - At b > WIDTH, o_sdata = 0.
  - The right slot repeats the same frame_reg.
- Frame load:
  - Occurs on the fall event where bit_cnt wraps to 0.
  - If the buffer is full: frame_reg ← buffer, buffer emptied.
  - Otherwise: frame_reg is held (last sample repeats) and o_underrun is set.
  - o_frame_tick = 1 for exactly the i_clk cycle of that fall event, including underrun frames.
- Buffer handshake:
  - o_sample_ready = !buf_full || load_now, where load_now = a frame-load event this cycle.
  - Transfer occurs when i_sample_valid && o_sample_ready. The buffer captures i_sample on that edge.
  - Load and accept in the same cycle: frame_reg takes the old buffer contents, and the buffer takes the new sample (stays full).
  - Valid while not ready: the sample is ignored, with no side effects.
- o_underrun clears only on reset.
- Latency: the MSB of a sample accepted into an empty buffer appears at the fall event following the next frame load, i.e. b = 1.
- The block adds no arithmetic or offset; the sample passes bit-exact.

Optional Feature:
- Macro: I2S_LEFT_JUSTIFIED_EN.
- Defined: left-justified format.
  - MSB at b = 0: o_sdata = frame_reg[WIDTH-1-b] for b < WIDTH, else 0.
  - LRCK polarity unchanged.
- Undefined: standard I2S with the one-bit delay, as above.
- All other timing, handshake and flag behaviour is identical in both builds.

Test Plan:
- Reset, CLK_DIV=4: hold i_reset for 3 cycles. Outputs match reset values. First o_bclk rise occurs 4 cycles after deassert; period is 8 i_clk cycles.
- Push 16'hA55A once, then capture one frame:
  - Left slot bits b = 1..16 = 1010010101011010.
  - b = 0 and b = 17..31 are 0.
  - Right slot is identical.
  - o_lrck goes high at bit_cnt = 32.
- Push 16'h8000, then no further samples: the following frame repeats 16'h8000, o_underrun = 1 on that load, o_frame_tick still pulses.
- Hold i_sample_valid = 1 with incrementing values 1, 2, 3, …: one sample is accepted per frame. o_sample_ready is low between loads except on the load cycle. Consecutive frames carry consecutive values with no skips.
- Assert i_reset at bit_cnt = 10 mid-frame: o_sdata = 0, o_lrck = 0 next cycle. After release, the first frame outputs 0 and o_underrun = 1 unless a sample is pushed before the first load.
- I2S_LEFT_JUSTIFIED_EN defined, push 16'hC001: left slot b = 0..15 = 1100000000000001, b = 16..31 = 0.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// Mono I2S transmitter: one-deep sample buffer, counter-divided BCLK, per-frame load tick.
// Define I2S_LEFT_JUSTIFIED_EN to select left-justified framing (MSB at slot bit 0).
module i2s_dac_tx #(
  parameter int CLK_DIV   = 4,
  parameter int WIDTH     = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sample,
  input  logic             i_sample_valid,
  output logic             o_sample_ready,
  output logic             o_frame_tick,
  output logic             o_underrun,
  output logic             o_bclk,
  output logic             o_lrck,
  output logic             o_sdata
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam int IDX_W = $clog2(WIDTH);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_nxt;
  logic [BIT_W-1:0] slot_b;
  logic [WIDTH-1:0] buf_q;
  logic [WIDTH-1:0] frame_reg;
  logic [WIDTH-1:0] frame_nxt;
  logic [IDX_W-1:0] idx;
  logic             buf_full;
  logic             div_wrap;
  logic             fall;
  logic             bit_last;
  logic             load_now;
  logic             accept;
  logic             sdata_nxt;

  assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall     = div_wrap && o_bclk;
  assign bit_last = (bit_cnt == BIT_W'(2 * SLOT_BITS - 1));
  assign load_now = fall && bit_last;
  assign bit_nxt  = bit_last ? '0 : bit_cnt + BIT_W'(1);
  assign slot_b   = (bit_nxt >= BIT_W'(SLOT_BITS)) ? bit_nxt - BIT_W'(SLOT_BITS) : bit_nxt;

  // Serialiser looks at the frame being loaded so slot bit 0 already sees the new sample.
  assign frame_nxt = (load_now && buf_full) ? buf_q : frame_reg;

  assign o_sample_ready = !buf_full || load_now;
  assign o_frame_tick   = load_now;
  assign accept         = i_sample_valid && o_sample_ready;

  always_comb begin
    idx       = '0;
    sdata_nxt = 1'b0;
`ifdef I2S_LEFT_JUSTIFIED_EN
    if (slot_b < BIT_W'(WIDTH)) begin
      idx       = IDX_W'(WIDTH - 1 - int'(slot_b));
      sdata_nxt = frame_nxt[idx];
    end
`else
    if ((slot_b != '0) && (slot_b <= BIT_W'(WIDTH))) begin
      idx       = IDX_W'(WIDTH - int'(slot_b));
      sdata_nxt = frame_nxt[idx];
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      o_bclk     <= 1'b0;
      o_lrck     <= 1'b0;
      o_sdata    <= 1'b0;
      o_underrun <= 1'b0;
      buf_full   <= 1'b0;
      buf_q      <= '0;
      frame_reg  <= '0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) o_bclk <= ~o_bclk;
      if (fall) begin
        bit_cnt <= bit_nxt;
        o_lrck  <= (bit_nxt >= BIT_W'(SLOT_BITS));
        o_sdata <= sdata_nxt;
      end
      if (load_now) begin
        frame_reg <= frame_nxt;
        if (!buf_full) o_underrun <= 1'b1;
      end
      if (accept) begin
        buf_q    <= i_sample;
        buf_full <= 1'b1;
      end else if (load_now) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx: vector table, scoreboard queue of expected slot words.
module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_sample = '0;
  logic        i_sample_valid = 1'b0;
  logic        o_sample_ready, o_frame_tick, o_underrun, o_bclk, o_lrck, o_sdata;

  i2s_dac_tx #(.CLK_DIV(4), .WIDTH(16), .SLOT_BITS(32)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_sample(i_sample), .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready), .o_frame_tick(o_frame_tick), .o_underrun(o_underrun),
    .o_bclk(o_bclk), .o_lrck(o_lrck), .o_sdata(o_sdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic [31:0] slot;
  } vec_t;

  vec_t        tbl[5];
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;
  logic        m_under;
  int          total = 0;
  int          passed = 0;
  int          pre_ones;
  logic        stream_en = 1'b0;
  logic [15:0] stream_val = 16'd1;
  int          rdy_err = 0;
  int          rdy_cnt = 0;

  function automatic logic [31:0] slot_word(input logic [15:0] s);
`ifdef I2S_LEFT_JUSTIFIED_EN
    return {s, 16'h0000};
`else
    return {1'b0, s, 15'h0000};
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [15:0] s, input logic [31:0] slot);
    int n = 0;
    i_sample = s;
    i_sample_valid = 1'b1;
    @(negedge clk);
    while (!o_sample_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!o_sample_ready) check("push_timeout", 64'd0, 64'd1);
    else exp_q.push_back(slot);
    @(posedge clk);
    #1 i_sample_valid = 1'b0;
  endtask

  // Waits for the next load tick, then captures the 64 bits of that frame.
  task automatic capture_frame(input string tag);
    int n = 0;
    int bits = 0;
    logic [63:0] d = '0;
    logic [63:0] lr = '0;
    logic [31:0] e;
    logic pb;
    logic first = 1'b1;
    pre_ones = 0;
    @(negedge clk);
    while (!o_frame_tick && n < 3000) begin
      pre_ones += int'(o_sdata);
      @(negedge clk);
      n++;
    end
    if (!o_frame_tick) begin
      check({tag, "_tick_timeout"}, 64'd0, 64'd1);
      return;
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e = last_exp;
      m_under = 1'b1;
    end
    last_exp = e;
    pb = o_bclk;
    n = 0;
    while (bits < 64 && n < 2000) begin
      @(negedge clk);
      n++;
      if (first) begin
        check({tag, "_tick_width"}, {63'd0, o_frame_tick}, 64'd0);
        check({tag, "_underrun"}, {63'd0, o_underrun}, {63'd0, m_under});
        first = 1'b0;
      end
      if (pb && !o_bclk) begin
        d  = {d[62:0], o_sdata};
        lr = {lr[62:0], o_lrck};
        bits++;
      end
      pb = o_bclk;
    end
    check({tag, "_bits"}, 64'(bits), 64'd64);
    check({tag, "_left"}, {32'd0, d[63:32]}, {32'd0, e});
    check({tag, "_right"}, {32'd0, d[31:0]}, {32'd0, e});
    check({tag, "_lrck"}, lr, {32'h0, 32'hFFFF_FFFF});
  endtask

  task automatic hold_reset(input int cycles);
    i_reset = 1'b1;
    i_sample_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    exp_q.delete();
    m_under = 1'b0;
    last_exp = '0;
  endtask

  // Streaming driver: keeps valid high, advances the value after each accepted transfer.
  initial begin
    logic acc = 1'b0;
    logic filled = 1'b0;
    forever begin
      @(negedge clk);
      if (acc) begin
        stream_val++;
        acc = 1'b0;
      end
      if (stream_en) begin
        if (filled) begin
          rdy_cnt++;
          if (o_sample_ready !== o_frame_tick) rdy_err++;
        end
        i_sample = stream_val;
        i_sample_valid = 1'b1;
        if (o_sample_ready) begin
          exp_q.push_back(slot_word(stream_val));
          acc = 1'b1;
          filled = 1'b1;
        end
      end
    end
  end

  initial begin
    int k;
    int n;
`ifdef I2S_LEFT_JUSTIFIED_EN
    tbl[0] = '{16'hA55A, 32'hA55A_0000};
    tbl[1] = '{16'hFFFF, 32'hFFFF_0000};
    tbl[2] = '{16'h0001, 32'h0001_0000};
    tbl[3] = '{16'hC001, 32'hC001_0000};
    tbl[4] = '{16'h8000, 32'h8000_0000};
`else
    tbl[0] = '{16'hA55A, 32'h52AD_0000};
    tbl[1] = '{16'hFFFF, 32'h7FFF_8000};
    tbl[2] = '{16'h0001, 32'h0000_8000};
    tbl[3] = '{16'hC001, 32'h6000_8000};
    tbl[4] = '{16'h8000, 32'h4000_0000};
`endif

    // Reset values and BCLK timing
    hold_reset(3);
    check("rst_bclk", {63'd0, o_bclk}, 64'd0);
    check("rst_lrck", {63'd0, o_lrck}, 64'd0);
    check("rst_sdata", {63'd0, o_sdata}, 64'd0);
    check("rst_tick", {63'd0, o_frame_tick}, 64'd0);
    check("rst_underrun", {63'd0, o_underrun}, 64'd0);
    check("rst_ready", {63'd0, o_sample_ready}, 64'd1);
    i_reset = 1'b0;
    k = 0;
    while (!o_bclk && k < 50) begin
      @(posedge clk);
      #1 k++;
    end
    check("first_rise", 64'(k), 64'd4);
    k = 0;
    while (o_bclk && k < 50) begin
      @(posedge clk);
      #1 k++;
    end
    while (!o_bclk && k < 50) begin
      @(posedge clk);
      #1 k++;
    end
    check("bclk_period", 64'(k), 64'd8);

    // Table vectors, one frame each
    for (int i = 0; i < 5; i++) begin
      push(tbl[i].s, tbl[i].slot);
      capture_frame($sformatf("vec%0d", i));
    end
    // No push: last sample repeats, underrun flagged
    capture_frame("underrun_frame");

    // Continuous streaming 1,2,3,...
    hold_reset(2);
    i_reset = 1'b0;
    stream_en = 1'b1;
    for (int f = 0; f < 4; f++) capture_frame($sformatf("stream%0d", f));
    stream_en = 1'b0;
    i_sample_valid = 1'b0;
    check("stream_ready_err", 64'(rdy_err), 64'd0);
    check("stream_ready_seen", {63'd0, rdy_cnt > 100}, 64'd1);

    // Mid-frame reset at bit_cnt = 10
    hold_reset(2);
    i_reset = 1'b0;
    push(16'hFFFF, slot_word(16'hFFFF));
    n = 0;
    @(negedge clk);
    while (!o_frame_tick && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("mid_tick_seen", {63'd0, o_frame_tick}, 64'd1);
    k = 0;
    n = 0;
    begin
      logic pb = o_bclk;
      while (k < 11 && n < 1000) begin
        @(negedge clk);
        n++;
        if (pb && !o_bclk) k++;
        pb = o_bclk;
      end
    end
    check("mid_b10_sdata", {63'd0, o_sdata}, 64'd1);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_sdata", {63'd0, o_sdata}, 64'd0);
    check("mid_rst_lrck", {63'd0, o_lrck}, 64'd0);
    check("mid_rst_bclk", {63'd0, o_bclk}, 64'd0);
    hold_reset(1);
    i_reset = 1'b0;
    check("mid_rel_underrun", {63'd0, o_underrun}, 64'd0);
    capture_frame("post_reset");
    check("post_reset_pre_ones", 64'(pre_ones), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
